// File: rtl/touch_pkg.sv
// Shared definitions for the touch-key LED array: per-channel LED modes and
// a counter-width helper used by the key filter.
package touch_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_MOMENT = 2'b01,
        MODE_LONG   = 2'b10,
        MODE_OFF    = 2'b11
    } led_mode_e;

    function automatic int cnt_width(input int range_max);
        if (range_max <= 1) begin
            return 1;
        end else begin
            return $clog2(range_max);
        end
    endfunction

endpackage

// File: rtl/touch_key_filter.sv
// One touch-key channel: input synchroniser, stable-count deglitch filter,
// filtered rising-edge pulse and long-press hold counter.
module touch_key_filter
    import touch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16,
    parameter int LONG_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic touch_key,
    output logic key_state,
    output logic press_pulse,
    output logic long_pulse,
    output logic press_rise
);

    localparam int FW = cnt_width(FILT_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    logic [FW-1:0]          fcnt_r;
    logic [FW-1:0]          fcnt_nxt_s;
    logic                   armed_r;
    logic                   armed_nxt_s;
    logic                   key_state_r;
    logic                   key_state_nxt_s;
    logic                   key_state_d_r;
    logic [HW-1:0]          hcnt_r;
    logic [HW-1:0]          hcnt_nxt_s;
    logic                   long_hit_s;
    logic                   press_pulse_r;
    logic                   long_pulse_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Deglitch filter; until a released level has been seen after reset the
    // counter instead measures low time, so a press held through reset is ignored.
    always_comb begin
        fcnt_nxt_s      = fcnt_r;
        key_state_nxt_s = key_state_r;
        armed_nxt_s     = armed_r;
        if (!armed_r) begin
            key_state_nxt_s = 1'b0;
            if (sync_out_s) begin
                fcnt_nxt_s = '0;
            end else if (fcnt_r == FILT_LAST) begin
                fcnt_nxt_s  = '0;
                armed_nxt_s = 1'b1;
            end else begin
                fcnt_nxt_s = fcnt_r + 1'b1;
            end
        end else if (sync_out_s == key_state_r) begin
            fcnt_nxt_s = '0;
        end else if (fcnt_r == FILT_LAST) begin
            fcnt_nxt_s      = '0;
            key_state_nxt_s = sync_out_s;
        end else begin
            fcnt_nxt_s = fcnt_r + 1'b1;
        end
    end

    // Hold counter: cleared while released, saturating while pressed
    always_comb begin
        if (!key_state_r) begin
            hcnt_nxt_s = '0;
        end else if (hcnt_r == LONG_MAX) begin
            hcnt_nxt_s = hcnt_r;
        end else begin
            hcnt_nxt_s = hcnt_r + 1'b1;
        end
    end

    assign long_hit_s = key_state_r && (hcnt_r == LONG_LAST);

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r        <= '0;
            fcnt_r        <= '0;
            armed_r       <= 1'b0;
            key_state_r   <= 1'b0;
            key_state_d_r <= 1'b0;
            hcnt_r        <= '0;
            press_pulse_r <= 1'b0;
            long_pulse_r  <= 1'b0;
        end else begin
            sync_r        <= {sync_r[SYNC_STAGES-2:0], touch_key};
            fcnt_r        <= fcnt_nxt_s;
            armed_r       <= armed_nxt_s;
            key_state_r   <= key_state_nxt_s;
            key_state_d_r <= key_state_r;
            hcnt_r        <= hcnt_nxt_s;
            press_pulse_r <= key_state_r & ~key_state_d_r;
            long_pulse_r  <= long_hit_s;
        end
    end

    // press_rise is the same condition press_pulse registers, so a toggle LED
    // can flip on the very edge the pulse appears.
    assign key_state   = key_state_r;
    assign press_pulse = press_pulse_r;
    assign long_pulse  = long_pulse_r;
    assign press_rise  = key_state_r & ~key_state_d_r;

endmodule

// File: rtl/touch_led_array.sv
// N-channel touch-key LED driver: one filter per key plus a per-channel LED
// mode (toggle, momentary, long-press toggle, off).
module touch_led_array
    import touch_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 16,
    parameter int LONG_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   touch_key,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   key_state,
    output logic [N_CH-1:0]   press_pulse,
    output logic [N_CH-1:0]   long_pulse
);

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            led_mode_e ch_mode_s;
            logic      press_rise_s;
            logic      led_nxt_s;
            logic      led_r;

            touch_key_filter #(
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_CYCLES(FILT_CYCLES),
                .LONG_CYCLES(LONG_CYCLES)
            ) u_filter (
                .clk        (clk),
                .rst        (rst),
                .touch_key  (touch_key[i]),
                .key_state  (key_state[i]),
                .press_pulse(press_pulse[i]),
                .long_pulse (long_pulse[i]),
                .press_rise (press_rise_s)
            );

            assign ch_mode_s = led_mode_e'(mode[2*i+1 -: 2]);

            // Next LED level for the channel's current mode
            always_comb begin
                led_nxt_s = led_r;
                case (ch_mode_s)
                    MODE_TOGGLE: begin
                        if (press_rise_s) begin
                            led_nxt_s = ~led_r;
                        end else begin
                            led_nxt_s = led_r;
                        end
                    end
                    MODE_MOMENT: led_nxt_s = key_state[i];
                    MODE_LONG: begin
                        if (long_pulse[i]) begin
                            led_nxt_s = ~led_r;
                        end else begin
                            led_nxt_s = led_r;
                        end
                    end
                    MODE_OFF: led_nxt_s = 1'b0;
                    default:  led_nxt_s = 1'b0;
                endcase
            end

            // LED register
            always_ff @(posedge clk) begin
                if (rst) begin
                    led_r <= 1'b0;
                end else begin
                    led_r <= led_nxt_s;
                end
            end

            assign led[i] = led_r;
        end
    endgenerate

endmodule

// File: tb/tb_touch_led_array.sv
// Directed self-checking bench for touch_led_array (4 channels, short filter
// and long-press thresholds so every scenario fits in a few hundred cycles).
module tb_touch_led_array;

    logic       clk;
    logic       rst;
    logic [3:0] touch_key;
    logic [7:0] mode;
    logic [3:0] led;
    logic [3:0] key_state;
    logic [3:0] press_pulse;
    logic [3:0] long_pulse;

    int passed;
    int total;
    int n;

    touch_led_array #(
        .N_CH(4), .SYNC_STAGES(2), .FILT_CYCLES(4), .LONG_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .touch_key  (touch_key),
        .mode       (mode),
        .led        (led),
        .key_state  (key_state),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        touch_key = 4'b0000;
        mode      = 8'b10_01_00_00;
        tick(3);
        check("rst_led", 32'(led), 32'h0);
        check("rst_key", 32'(key_state), 32'h0);
        check("rst_press", 32'(press_pulse), 32'h0);
        check("rst_long", 32'(long_pulse), 32'h0);
        rst = 1'b0;
        tick(10);
        check("idle_out", 32'({led, key_state, press_pulse, long_pulse}), 32'h0);

        // ---- ch0 toggle: press 1 held 30 cycles ----
        touch_key[0] = 1'b1;
        tick(5);
        check("t1_key_early", 32'(key_state[0]), 32'h0);
        tick(1);
        check("t1_key_rise", 32'(key_state[0]), 32'h1);
        check("t1_press_early", 32'(press_pulse[0]), 32'h0);
        check("t1_led_early", 32'(led[0]), 32'h0);
        tick(1);
        check("t1_press", 32'(press_pulse[0]), 32'h1);
        check("t1_led_on", 32'(led[0]), 32'h1);
        tick(1);
        check("t1_press_once", 32'(press_pulse[0]), 32'h0);
        n = 0;
        for (int k = 0; k < 22; k++) begin
            tick(1);
            if (k == 17) check("t1_long_at20", 32'(long_pulse[0]), 32'h1);
            n += int'(long_pulse[0]);
        end
        check("t1_long_count", 32'(n), 32'h1);
        touch_key[0] = 1'b0;
        tick(5);
        check("t1_rel_key_early", 32'(key_state[0]), 32'h1);
        tick(1);
        check("t1_rel_key", 32'(key_state[0]), 32'h0);
        tick(1);
        check("t1_rel_nopulse", 32'(press_pulse[0]), 32'h0);
        check("t1_rel_led", 32'(led[0]), 32'h1);
        tick(8);

        // ---- ch0 toggle: short press 2 turns LED off, no long pulse ----
        touch_key[0] = 1'b1;
        tick(7);
        check("t2_press", 32'(press_pulse[0]), 32'h1);
        check("t2_led_off", 32'(led[0]), 32'h0);
        tick(3);
        touch_key[0] = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            n += int'(long_pulse[0]);
        end
        check("t2_no_long", 32'(n), 32'h0);
        tick(4);

        // ---- ch0 mode change while held ----
        touch_key[0] = 1'b1;
        tick(7);
        check("mc_led_on", 32'(led[0]), 32'h1);
        mode[1:0] = 2'b11;
        tick(1);
        check("mc_off", 32'(led[0]), 32'h0);
        mode[1:0] = 2'b01;
        tick(1);
        check("mc_moment", 32'(led[0]), 32'h1);
        touch_key[0] = 1'b0;
        tick(6);
        check("mc_rel_key", 32'(key_state[0]), 32'h0);
        check("mc_rel_led_lag", 32'(led[0]), 32'h1);
        tick(1);
        check("mc_rel_led", 32'(led[0]), 32'h0);
        mode[1:0] = 2'b00;
        tick(4);

        // ---- ch1 glitch rejection: 1..3 cycle pulses ----
        for (int w = 1; w <= 3; w++) begin
            touch_key[1] = 1'b1;
            tick(w);
            touch_key[1] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick(1);
                check("gl_quiet", 32'({key_state[1], press_pulse[1], led[1]}), 32'h0);
            end
        end
        // 4-cycle pulse is exactly long enough to be accepted
        touch_key[1] = 1'b1;
        tick(4);
        touch_key[1] = 1'b0;
        tick(2);
        check("gl4_key", 32'(key_state[1]), 32'h1);
        tick(1);
        check("gl4_press", 32'(press_pulse[1]), 32'h1);
        check("gl4_led", 32'(led[1]), 32'h1);
        tick(3);
        check("gl4_key_fall", 32'(key_state[1]), 32'h0);
        tick(6);

        // ---- ch2 momentary held 12 cycles ----
        touch_key[2] = 1'b1;
        tick(6);
        check("mo_key", 32'(key_state[2]), 32'h1);
        check("mo_led_lag", 32'(led[2]), 32'h0);
        tick(1);
        check("mo_led_on", 32'(led[2]), 32'h1);
        tick(5);
        touch_key[2] = 1'b0;
        tick(6);
        check("mo_key_fall", 32'(key_state[2]), 32'h0);
        check("mo_led_hold", 32'(led[2]), 32'h1);
        tick(1);
        check("mo_led_off", 32'(led[2]), 32'h0);
        tick(4);

        // ---- ch3 long-press mode ----
        touch_key[3] = 1'b1;
        tick(10);
        touch_key[3] = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            n += int'(long_pulse[3]);
        end
        check("lp_short_nolong", 32'(n), 32'h0);
        check("lp_short_led", 32'(led[3]), 32'h0);
        touch_key[3] = 1'b1;
        tick(6);
        check("lp_key", 32'(key_state[3]), 32'h1);
        tick(19);
        check("lp_long_early", 32'(long_pulse[3]), 32'h0);
        tick(1);
        check("lp_long", 32'(long_pulse[3]), 32'h1);
        check("lp_led_lag", 32'(led[3]), 32'h0);
        tick(1);
        check("lp_long_once", 32'(long_pulse[3]), 32'h0);
        check("lp_led_on", 32'(led[3]), 32'h1);
        n = 0;
        for (int k = 0; k < 13; k++) begin
            tick(1);
            n += int'(long_pulse[3]);
        end
        check("lp_no_second", 32'(n), 32'h0);
        touch_key[3] = 1'b0;
        tick(8);
        check("lp_rel_led", 32'(led[3]), 32'h1);
        tick(4);

        // ---- reset mid-press on ch3 (momentary), hold count 15 ----
        mode[7:6] = 2'b01;
        touch_key[3] = 1'b1;
        tick(21);
        rst = 1'b1;
        tick(1);
        check("rm_led", 32'(led), 32'h0);
        check("rm_key", 32'(key_state), 32'h0);
        check("rm_pulses", 32'({press_pulse, long_pulse}), 32'h0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if ({key_state[3], press_pulse[3], long_pulse[3], led[3]} != 4'b0000) n++;
        end
        check("rm_discarded", 32'(n), 32'h0);
        touch_key[3] = 1'b0;
        tick(10);
        touch_key[3] = 1'b1;
        tick(6);
        check("rm_repress_key", 32'(key_state[3]), 32'h1);
        check("rm_repress_led_lag", 32'(led[3]), 32'h0);
        tick(1);
        check("rm_repress_pulse", 32'(press_pulse[3]), 32'h1);
        check("rm_repress_led", 32'(led[3]), 32'h1);
        touch_key[3] = 1'b0;
        tick(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
